// File: rtl/wave_capture_ctrl.sv
// rtl/wave_capture_ctrl.sv - ping-pong capture controller for the waveform display RAM
// Arms on a rising zero crossing, writes one half-buffer, then flips halves during display idle.
module wave_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH_LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                  wave_display_idle,
  output logic [DEPTH_LOG2:0]   write_address,
  output logic                  write_enable,
  output logic [7:0]            write_sample,
  output logic                  read_index,
  output logic                  armed
);

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_ACTIVE,
    ST_WAIT
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] LAST_COUNT = '1;

  state_t                state;
  logic [DEPTH_LOG2-1:0] count;
  logic [DEPTH_LOG2-1:0] addr_lo;
  logic                  prev_neg;
  logic                  sample_neg;
  logic [7:0]            disp_sample;

  assign sample_neg  = new_sample_in[SAMPLE_WIDTH-1];
  // Top byte converted to offset binary so 0x80 is the display's zero line.
  assign disp_sample = {~new_sample_in[SAMPLE_WIDTH-1], new_sample_in[SAMPLE_WIDTH-2 -: 7]};

  // The half-select bit tracks read_index directly so writes can never land in the displayed half.
  assign write_address = {~read_index, addr_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ARMED;
      count        <= '0;
      addr_lo      <= '0;
      prev_neg     <= 1'b0;
      read_index   <= 1'b0;
      write_enable <= 1'b0;
      write_sample <= 8'h00;
      armed        <= 1'b1;
    end else begin
      write_enable <= 1'b0;
      case (state)
        ST_ARMED: begin
          if (new_sample_ready) begin
            prev_neg <= sample_neg;
            if (prev_neg && !sample_neg) begin
              write_enable <= 1'b1;
              addr_lo      <= '0;
              write_sample <= disp_sample;
              count        <= {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
              state        <= ST_ACTIVE;
              armed        <= 1'b0;
            end
          end
        end

        ST_ACTIVE: begin
          if (new_sample_ready) begin
            prev_neg     <= sample_neg;
            write_enable <= 1'b1;
            addr_lo      <= count;
            write_sample <= disp_sample;
            count        <= count + 1'b1;
            if (count == LAST_COUNT) begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // Flip only during blanking so the display never sees a half-written buffer.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            prev_neg   <= 1'b0;
            state      <= ST_ARMED;
            armed      <= 1'b1;
          end
        end

        default: begin
          state <= ST_ARMED;
          armed <= 1'b1;
        end
      endcase
    end
  end

endmodule
